// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared definitions for the UART TX arbiter.
// Holds the arbiter FSM state encoding and the index-width helper.
package uart_arb_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_SEND  = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  // Bits needed to hold an index in 0..value-1, never less than one bit
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Returns the first valid index strictly after last_owner, wrapping around,
// so the previous owner is the lowest-priority candidate.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [IDX_W-1:0]   index,
  output logic               found
);

  // Walk the candidates in rotation order and keep the first valid one
  always_comb begin : pick_loop
    int cand;
    logic [IDX_W-1:0] cand_idx;
    index    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand     = (int'(last_owner) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && valid[cand_idx]) begin
        index = cand_idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX core among NUM_REQ byte sources.
// Round-robin grant, locked for a whole packet so packets never interleave.
// Optional forced release of a stalled packet lock: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
`ifdef UART_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 50000
`endif
) (
  input  logic                      clk_50m,
  input  logic                      sw_rst_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [DATA_W-1:0]         tx_data_o,
  output logic                      tx_start_o,
  input  logic                      tx_busy_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      timeout_o
);

  localparam int IDX_W = clog2(NUM_REQ);

  arb_state_e        state;
  arb_state_e        next_state;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  last_owner;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic              last_flag;
  logic              owner_valid;
  logic              owner_last;
  logic [DATA_W-1:0] owner_byte;
  logic              handshake;
  logic              timeout_hit;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .valid      (req_valid_i),
    .last_owner (last_owner),
    .index      (pick_idx),
    .found      (pick_found)
  );

  // Route the owner's request lines and raise only the owner's ready bit
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_byte  = '0;
    req_ready_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner == IDX_W'(k)) begin
        owner_valid    = req_valid_i[k];
        owner_last     = req_last_i[k];
        owner_byte     = req_data_i[k*DATA_W +: DATA_W];
        req_ready_o[k] = (state == ST_GRANT) && req_valid_i[k] && !tx_busy_i;
      end
    end
  end

  assign handshake = (state == ST_GRANT) && owner_valid && !tx_busy_i;

  // Next-state logic; SEND is a guard cycle before busy is trusted again
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (pick_found) next_state = ST_GRANT;
      ST_GRANT: begin
        if (handshake) next_state = ST_SEND;
        else if (timeout_hit) next_state = ST_IDLE;
      end
      ST_SEND:  next_state = ST_DRAIN;
      ST_DRAIN: if (!tx_busy_i) next_state = last_flag ? ST_IDLE : ST_GRANT;
      default:  next_state = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_50m or negedge sw_rst_n) begin
    if (!sw_rst_n) state <= ST_IDLE;
    else           state <= next_state;
  end

  // Owner bookkeeping and registered outputs to the TX core
  always_ff @(posedge clk_50m or negedge sw_rst_n) begin
    if (!sw_rst_n) begin
      owner      <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
      last_flag  <= 1'b0;
      tx_data_o  <= '0;
      tx_start_o <= 1'b0;
      grant_o    <= '0;
    end else begin
      tx_start_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            owner   <= pick_idx;
            grant_o <= NUM_REQ'(1) << pick_idx;
          end
        end
        ST_GRANT: begin
          if (handshake) begin
            tx_data_o  <= owner_byte;
            tx_start_o <= 1'b1;
            last_flag  <= owner_last;
          end else if (timeout_hit) begin
            last_owner <= owner;
            grant_o    <= '0;
          end
        end
        ST_DRAIN: begin
          if (!tx_busy_i && last_flag) begin
            last_owner <= owner;
            grant_o    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] idle_cnt;
  logic             idle_cycle;

  assign idle_cycle  = (state == ST_GRANT) && !owner_valid;
  assign timeout_hit = idle_cycle && (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Count owner-silent cycles inside a locked packet; pulse on forced release
  always_ff @(posedge clk_50m or negedge sw_rst_n) begin
    if (!sw_rst_n) begin
      idle_cnt  <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= timeout_hit;
      if (handshake || timeout_hit || state != ST_GRANT) idle_cnt <= '0;
      else if (idle_cycle) idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: self-checking bench for uart_tx_arbiter.
// Requesters are byte queues; a small TX core model drives tx_busy_i.
// Expected byte order comes from a packet-level rotation model.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;

  typedef struct packed { logic [7:0] data; logic last; } byte_t;
  typedef struct packed { logic [3:0] grant; logic [7:0] data; } start_t;
  typedef struct packed { logic [3:0] mask; logic [3:0] exp_grant; logic [7:0] exp_data; } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [3:0]  grant;
  logic        timeout_sig;

  int     n_checks = 0;
  int     n_fails = 0;
  int     cycle_num = 0;
  int     frame_len = 10;
  int     gap_max = 0;
  int     busy_cnt;
  int     gap [NREQ];
  int     model_last = NREQ - 1;
  logic [3:0] hs_mask = '0;
  byte_t  q  [NREQ][$];
  byte_t  mq [NREQ][$];
  start_t start_log[$];
  int     start_cycle[$];
  int     hs_cycle[$];
  int     timeout_cycle[$];

  uart_tx_arbiter #(
    .NUM_REQ (NREQ),
    .DATA_W  (8)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (100)
`endif
  ) dut (
    .clk_50m     (clk),
    .sw_rst_n    (rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .tx_data_o   (tx_data),
    .tx_start_o  (tx_start),
    .tx_busy_i   (tx_busy),
    .grant_o     (grant),
    .timeout_o   (timeout_sig)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  // TX core model: busy for frame_len cycles starting the cycle after a start
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cnt <= 0;
    else if (tx_start) busy_cnt <= frame_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // Hard time limit so the run always ends
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive requester lines from their queues, consuming bytes that handshook
  task automatic applyStimulus();
    for (int k = 0; k < NREQ; k++) begin
      if (hs_mask[k] && q[k].size() > 0) begin
        if (!q[k][0].last && gap_max > 0) gap[k] = int'($urandom_range(0, gap_max));
        void'(q[k].pop_front());
      end else if (gap[k] > 0) begin
        gap[k]--;
      end
      if (q[k].size() > 0 && gap[k] == 0) begin
        req_valid[k]          = 1'b1;
        req_data[k*8 +: 8]    = q[k][0].data;
        req_last[k]           = q[k][0].last;
      end else begin
        req_valid[k] = 1'b0;
        req_last[k]  = 1'b0;
      end
    end
  endtask

  // One clock: drive after the edge, sample and check mid-cycle
  task automatic stepCycle();
    @(posedge clk);
    #1;
    cycle_num++;
    applyStimulus();
    @(negedge clk);
    hs_mask = req_valid & req_ready;
    checkOutput("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    checkOutput("start_vs_busy", 32'(tx_start & tx_busy), 32'd0);
    if (tx_start) begin
      start_log.push_back('{grant: grant, data: tx_data});
      start_cycle.push_back(cycle_num);
    end
    if (timeout_sig) timeout_cycle.push_back(cycle_num);
    if (hs_mask != 0) hs_cycle.push_back(cycle_num);
  endtask

  task automatic clearStimulus();
    for (int k = 0; k < NREQ; k++) begin
      q[k].delete();
      mq[k].delete();
      gap[k] = 0;
    end
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    hs_mask   = '0;
  endtask

  task automatic pushByte(input int k, input logic [7:0] data, input logic last);
    q[k].push_back('{data: data, last: last});
    mq[k].push_back('{data: data, last: last});
  endtask

  task automatic clearLogs();
    start_log.delete();
    start_cycle.delete();
    hs_cycle.delete();
    timeout_cycle.delete();
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    clearStimulus();
    repeat (2) @(negedge clk);
    checkOutput("reset_grant", 32'(grant), 32'd0);
    checkOutput("reset_start", 32'(tx_start), 32'd0);
    checkOutput("reset_data", 32'(tx_data), 32'd0);
    checkOutput("reset_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_timeout", 32'(timeout_sig), 32'd0);
    rst_n = 1'b1;
    model_last = NREQ - 1;
  endtask

  task automatic waitStarts(input int n, input int max_cycles, input string name);
    int c;
    c = 0;
    while (start_log.size() < n && c < max_cycles) begin
      stepCycle();
      c++;
    end
    checkOutput(name, 32'(start_log.size() >= n), 32'd1);
  endtask

  // Packet-level model: serve whole packets in rotation after the last owner
  task automatic runModelCheck(input string name, input int max_cycles);
    start_t exp_q[$];
    byte_t  rec;
    int     found;
    int     c;
    bit     all_empty;
    forever begin
      found = -1;
      for (int i = 1; i <= NREQ; i++) begin
        if (found < 0 && mq[(model_last + i) % NREQ].size() > 0) found = (model_last + i) % NREQ;
      end
      if (found < 0) break;
      do begin
        rec = mq[found].pop_front();
        exp_q.push_back('{grant: 4'(1 << found), data: rec.data});
      end while (!rec.last && mq[found].size() > 0);
      model_last = found;
    end
    clearLogs();
    c = 0;
    all_empty = 1'b0;
    while (c < max_cycles) begin
      stepCycle();
      c++;
      all_empty = 1'b1;
      for (int k = 0; k < NREQ; k++) if (q[k].size() > 0) all_empty = 1'b0;
      if (all_empty && grant == 4'd0 && !tx_busy && !tx_start) break;
    end
    checkOutput({name, "_drained"}, 32'(all_empty && grant == 4'd0), 32'd1);
    checkOutput({name, "_count"}, 32'(start_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < start_log.size(); i++) begin
      checkOutput($sformatf("%s_data%0d", name, i), 32'(start_log[i].data), 32'(exp_q[i].data));
      checkOutput($sformatf("%s_grant%0d", name, i), 32'(start_log[i].grant), 32'(exp_q[i].grant));
    end
  endtask

  initial begin
    vec_t   vecs[6];
    int     base;
    int     elapsed;
    logic [7:0] order_exp[5];

    vecs[0] = '{mask: 4'b0001, exp_grant: 4'b0001, exp_data: 8'h80};
    vecs[1] = '{mask: 4'b0110, exp_grant: 4'b0010, exp_data: 8'h81};
    vecs[2] = '{mask: 4'b1000, exp_grant: 4'b1000, exp_data: 8'h83};
    vecs[3] = '{mask: 4'b1100, exp_grant: 4'b0100, exp_data: 8'h82};
    vecs[4] = '{mask: 4'b1010, exp_grant: 4'b0010, exp_data: 8'h81};
    vecs[5] = '{mask: 4'b1111, exp_grant: 4'b0001, exp_data: 8'h80};

    // First winner after reset for several request masks
    frame_len = 4;
    gap_max   = 0;
    for (int v = 0; v < 6; v++) begin
      applyReset();
      for (int k = 0; k < NREQ; k++) if (vecs[v].mask[k]) pushByte(k, 8'h80 + 8'(k), 1'b1);
      runModelCheck($sformatf("vec%0d", v), 200);
      checkOutput($sformatf("vec%0d_first_grant", v), 32'(start_log[0].grant), 32'(vecs[v].exp_grant));
      checkOutput($sformatf("vec%0d_first_data", v), 32'(start_log[0].data), 32'(vecs[v].exp_data));
    end

    // Single two-byte packet: ready at cycle 1, starts at cycles 2 and 15
    applyReset();
    frame_len = 10;
    pushByte(0, 8'h55, 1'b0);
    pushByte(0, 8'hAA, 1'b1);
    base = cycle_num + 1;
    runModelCheck("timing", 200);
    checkOutput("timing_first_ready", 32'(hs_cycle[0] - base), 32'd1);
    checkOutput("timing_start0", 32'(start_cycle[0] - base), 32'd2);
    checkOutput("timing_start1", 32'(start_cycle[1] - base), 32'd15);
    checkOutput("timing_data_hold", 32'(tx_data), 32'h0000_00AA);

    // All four at once from reset, requester 1 re-queues a second packet
    applyReset();
    frame_len = 3;
    for (int k = 0; k < NREQ; k++) pushByte(k, 8'h10 + 8'(k), 1'b1);
    pushByte(1, 8'h21, 1'b1);
    runModelCheck("simul", 400);
    order_exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h21};
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("simul_order%0d", i), 32'(start_log[i].data), 32'(order_exp[i]));

    // Packet lock: requester 1 waits for all of requester 2's packet
    applyReset();
    frame_len = 6;
    gap_max   = 3;
    clearLogs();
    pushByte(2, 8'h30, 1'b0);
    pushByte(2, 8'h31, 1'b0);
    pushByte(2, 8'h32, 1'b1);
    waitStarts(1, 50, "lock_first_start");
    pushByte(1, 8'h40, 1'b1);
    waitStarts(4, 300, "lock_all_starts");
    order_exp = '{8'h30, 8'h31, 8'h32, 8'h40, 8'h00};
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("lock_order%0d", i), 32'(start_log[i].data), 32'(order_exp[i]));
    checkOutput("lock_grant2", 32'(start_log[2].grant), 32'b0100);
    checkOutput("lock_grant3", 32'(start_log[3].grant), 32'b0010);
    repeat (30) stepCycle();

    // Reset during DRAIN of byte 2 of 4
    applyReset();
    frame_len = 10;
    gap_max   = 0;
    clearLogs();
    for (int i = 0; i < 4; i++) pushByte(0, 8'h60 + 8'(i), i == 3);
    waitStarts(2, 100, "rst_reach_byte2");
    stepCycle();
    stepCycle();
    checkOutput("rst_pre_grant", 32'(grant), 32'b0001);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_start", 32'(tx_start), 32'd0);
    checkOutput("rst_mid_data", 32'(tx_data), 32'd0);
    checkOutput("rst_mid_grant", 32'(grant), 32'd0);
    checkOutput("rst_mid_ready", 32'(req_ready), 32'd0);
    clearStimulus();
    repeat (3) stepCycle();
    checkOutput("rst_no_start", 32'(start_log.size()), 32'd2);
    rst_n = 1'b1;
    model_last = NREQ - 1;
    pushByte(1, 8'h51, 1'b1);
    pushByte(0, 8'h50, 1'b1);
    runModelCheck("rst_recover", 200);
    checkOutput("rst_first_winner", 32'(start_log[0].grant), 32'b0001);

    // Randomised packets with mid-packet valid gaps against the rotation model
    gap_max = 3;
    for (int it = 0; it < 20; it++) begin
      frame_len = int'($urandom_range(1, 12));
      for (int k = 0; k < NREQ; k++) begin
        int npk;
        npk = int'($urandom_range(0, 2));
        for (int p = 0; p < npk; p++) begin
          int len;
          len = int'($urandom_range(1, 4));
          for (int b = 0; b < len; b++) pushByte(k, 8'($urandom), b == len - 1);
        end
      end
      runModelCheck($sformatf("rand%0d", it), 1500);
    end

    // Owner stalls mid-packet while requester 0 waits
    applyReset();
    frame_len = 10;
    gap_max   = 0;
    clearLogs();
    pushByte(3, 8'h70, 1'b0);
    waitStarts(1, 50, "stall_first_start");
    pushByte(0, 8'h01, 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
    begin
      int c;
      c = 0;
      while (timeout_cycle.size() == 0 && c < 400) begin
        stepCycle();
        c++;
      end
    end
    checkOutput("timeout_seen", 32'(timeout_cycle.size() > 0), 32'd1);
    if (timeout_cycle.size() > 0) begin
      elapsed = timeout_cycle[0] - start_cycle[0];
      checkOutput("timeout_delay", 32'(elapsed >= 100 && elapsed <= 100 + frame_len + 3), 32'd1);
      checkOutput("timeout_grant_drop", 32'(grant), 32'd0);
      stepCycle();
      checkOutput("timeout_one_cycle", 32'(timeout_sig), 32'd0);
      checkOutput("timeout_next_grant", 32'(grant), 32'b0001);
      waitStarts(2, 50, "timeout_req0_start");
      checkOutput("timeout_req0_data", 32'(start_log[1].data), 32'h01);
    end
`else
    elapsed = 0;
    repeat (300) stepCycle();
    checkOutput("stall_no_timeout", 32'(timeout_cycle.size()), 32'd0);
    checkOutput("stall_grant_held", 32'(grant), 32'b1000);
    checkOutput("stall_req0_blocked", 32'(start_log.size()), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
